// File: rtl/add64.sv
`default_nettype none
// ============================================================================
//  Module      : add64
//  Description : 64-bit signed adder built from a ripple chain of 1-bit full
//                adders, with a registered sum and signed-overflow flag.
//                One-cycle latency, one operand pair accepted per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  add64_fa : single-bit full adder, the building block of the carry chain
// ----------------------------------------------------------------------------
module add64_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// ----------------------------------------------------------------------------
//  add64 : top level
// ----------------------------------------------------------------------------
module add64 (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] ans,
   output logic        overflow
);

   localparam int c_WIDTH = 64;

   // w_carry[i] is the carry into bit i; w_carry[c_WIDTH] is the carry out of
   // the MSB, used only for overflow detection and never exposed as a port.
   logic [c_WIDTH:0]   w_carry;
   logic [c_WIDTH-1:0] w_sum;
   logic               w_overflow;

   logic [c_WIDTH-1:0] r_ans;
   logic               r_overflow;

   assign w_carry[0] = 1'b0;

   // One full adder per bit position, carries rippling LSB to MSB.
   generate
      for (genvar gi = 0; gi < c_WIDTH; gi++) begin : g_bit
         add64_fa u_fa (
            .i_a    (a[gi]),
            .i_b    (b[gi]),
            .i_cin  (w_carry[gi]),
            .o_sum  (w_sum[gi]),
            .o_cout (w_carry[gi+1])
         );
      end
   endgenerate

   // Signed overflow: the carry into the sign bit disagrees with the carry out
   // of it. This is identical to "operands share a sign the result lacks", so
   // mixed-sign operands can never raise it.
   assign w_overflow = w_carry[c_WIDTH-1] ^ w_carry[c_WIDTH];

   // Output register: reset wins over capture and discards the sampled pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ans      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_ans      <= w_sum;
         r_overflow <= w_overflow;
      end
   end

   assign ans      = r_ans;
   assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_add64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add64
//  Description : Scoreboard bench for add64. The driver pushes the expected
//                result of each applied pair; a monitor pops and compares one
//                cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add64;

   logic        clk;
   logic        rst;
   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] ans;
   logic        overflow;

   typedef struct {
      logic [63:0] ans;
      logic        ovf;
      string       name;
   } exp_t;

   exp_t q_exp[$];

   int n_total = 0;
   int n_pass  = 0;

   add64 u_dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .ans      (ans),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one pair at the falling edge and record what must appear after the
   // following rising edge.
   task automatic drive(input logic r, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] ea, input logic eo, input string nm);
      exp_t e;
      @(negedge clk);
      rst = r;
      a   = x;
      b   = y;
      e.ans  = ea;
      e.ovf  = eo;
      e.name = nm;
      q_exp.push_back(e);
   endtask

   // Monitor: shortly after each rising edge, compare against the oldest entry.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q_exp.size() > 0) begin
         e = q_exp.pop_front();
         n_total++;
         if (ans === e.ans) n_pass++;
         else $display("FAIL %s ans: got %h expected %h", e.name, ans, e.ans);
         n_total++;
         if (overflow === e.ovf) n_pass++;
         else $display("FAIL %s overflow: got %b expected %b", e.name, overflow, e.ovf);
      end
   end

   initial begin
      logic [63:0] x, y, s;
      logic        o;
      rst = 1'b1;
      a   = 64'd0;
      b   = 64'd0;

      // Reset held for two edges with live operands, then release.
      drive(1'b1, 64'd5, 64'd7, 64'd0, 1'b0, "reset_0");
      drive(1'b1, 64'd5, 64'd7, 64'd0, 1'b0, "reset_1");
      drive(1'b0, 64'd5, 64'd7, 64'd12, 1'b0, "post_reset");

      // Directed boundary vectors.
      drive(1'b0, 64'h7FFF_FFFF_FFFF_FFFE, 64'd1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, "pos_near_max");
      drive(1'b0, 64'h7FFF_FFFF_FFFF_FFFE, 64'd2,
            64'h8000_0000_0000_0000, 1'b1, "pos_overflow");
      drive(1'b0, -64'sd78382942, -64'sd35682899912,
            -64'sd35761282854, 1'b0, "negatives");
      drive(1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "neg_overflow");
      drive(1'b0, 64'd5, -64'sd5, 64'd0, 1'b0, "opposite_zero");
      drive(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "mixed_extremes");
      drive(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, "carry_discard");

      // Back-to-back pairs.
      drive(1'b0, 64'd587619328768, 64'd9923145637281,
            64'd10510764966049, 1'b0, "pipe_0");
      drive(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, "pipe_1");

      // Reset asserted mid-stream discards an overflowing pair, then resumes.
      drive(1'b0, 64'd100, 64'd23, 64'd123, 1'b0, "pre_midreset");
      drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, "midreset");
      drive(1'b0, 64'd40, 64'd2, 64'd42, 1'b0, "post_midreset");

      // Random pairs against a behavioural reference.
      for (int i = 0; i < 1000; i++) begin
         x = {$urandom(), $urandom()};
         y = {$urandom(), $urandom()};
         if (i % 4 == 0) y[63] = x[63];
         s = x + y;
         o = (x[63] == y[63]) && (s[63] != x[63]);
         drive(1'b0, x, y, s, o, "random");
      end

      repeat (3) @(negedge clk);
      n_total++;
      if (q_exp.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, expected 0", q_exp.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/add64.md
ADD64 -- requirements
Module: add64

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 64 bits.
REQ-002 `clk`  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 `rst`  input  1  reset, synchronous and active-high.
REQ-004 `a`  input  64  signed two's-complement operand A.
REQ-005 `b`  input  64  signed two's-complement operand B.
REQ-006 `ans`  output  64  registered signed sum A+B, modulo 2^64.
REQ-007 `overflow`  output  1  registered signed-overflow flag for the same sum.
REQ-008 Port order SHALL be `clk`, `rst`, `a`, `b`, `ans`, `overflow`.

Function
REQ-009 The block SHALL compute the sum combinationally as a 64-stage ripple-carry chain of 1-bit full adders.
- Each stage: sum = a^b^cin; cout = (a&b)|(a&cin)|(b&cin).
- Stage 0 cin = 0.
REQ-010 The raw sum SHALL equal (a + b) mod 2^64 for all input pairs; carry-out of bit 63 SHALL be discarded and SHALL NOT be exposed.
REQ-011 The raw overflow SHALL be 1 exactly when a[63]==b[63] and sum[63]!=a[63], and 0 otherwise.
- Equivalent definition: carry into bit 63 XOR carry out of bit 63.
REQ-012 Each rising `clk` edge with `rst`=0 SHALL register the raw sum into `ans` and the raw overflow into `overflow`.
REQ-013 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N, and hold until the next edge.
REQ-014 A new operand pair SHALL be accepted every cycle; there is no handshake and no stall.
REQ-015 Outputs SHALL be glitch-free registers, with no combinational path from `a`/`b` to `ans`/`overflow`.
REQ-016 Mixed-sign operands SHALL never set `overflow`.
REQ-017 Wrap-around cases:
- Positive + positive crossing 0x7FFF_FFFF_FFFF_FFFF SHALL wrap into the negative range with `overflow`=1.
- Negative + negative below 0x8000_0000_0000_0000 SHALL wrap into the positive range with `overflow`=1.
REQ-018 A result of exactly 0 from opposite-sign operands (e.g. 5 + -5) SHALL give `ans`=0, `overflow`=0.
REQ-019 The block SHALL contain no X-propagating constructs; with known inputs, outputs SHALL be fully known after the first clock edge.

Reset
REQ-020 When `rst`=1 at a rising edge, `ans` SHALL become 64'h0 and `overflow` SHALL become 0, regardless of `a`/`b`.
REQ-021 Reset SHALL have priority over the operand capture.
REQ-022 Reset asserted mid-stream SHALL discard the operand pair sampled at that edge.
REQ-023 After `rst` deasserts, the first edge SHALL resume normal capture with 1-cycle latency.
REQ-024 Reset SHALL have no asynchronous effect; outputs SHALL change only at clock edges.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset: hold `rst`=1 with a=5, b=7 for 2 edges -> `ans`=0, `overflow`=0; deassert -> next edge `ans`=12.
- Positive near-max: a=0x7FFFFFFFFFFFFFFE, b=1 -> `ans`=0x7FFFFFFFFFFFFFFF, `overflow`=0.
- Positive overflow: a=0x7FFFFFFFFFFFFFFE, b=2 -> `ans`=0x8000000000000000, `overflow`=1.
- Negatives: a=-78382942, b=-35682899912 -> `ans`=-35761282854, `overflow`=0.
- Negative overflow: a=0x8000000000000000, b=0xFFFFFFFFFFFFFFFF -> `ans`=0x7FFFFFFFFFFFFFFF, `overflow`=1.
- Pipelining: back-to-back pairs (587619328768, 9923145637281) then (0, 0) -> `ans`=10510764966049, then 0 on consecutive cycles.
REQ-026 The bench SHALL also apply at least 1000 random operand pairs and compare against a reference model: (a+b) mod 2^64 and the sign-rule overflow, checked one cycle later.
